// File: rtl/indicator_pkg.sv
// Shared constants and types for the LED indicator sequencer.
// Command bytes, chase state encoding and the decoded-command record.
package indicator_pkg;

    localparam logic [7:0] CMD_RUN     = "r";
    localparam logic [7:0] CMD_STOP    = "s";
    localparam logic [7:0] CMD_FASTER  = "+";
    localparam logic [7:0] CMD_SLOWER  = "-";
    localparam logic [7:0] DIGIT_FIRST = "1";
    localparam logic [7:0] DIGIT_LAST  = "5";

    localparam int NUM_LEDS = 5;

    typedef enum logic {IDLE, RUN} state_t;

    // One-hot view of the byte on the current rx_ready strobe.
    typedef struct packed {
        logic pass;
        logic run;
        logic stop;
        logic faster;
        logic slower;
    } cmd_t;

endpackage

// File: rtl/indicator_sequencer_step_timer.sv
// Chase prescaler: counts to (BASE_TICKS << shift) - 1 while enabled and
// pulses tick on the terminal count; clr or !en returns it to 0.
module step_timer #(
    parameter int BASE_TICKS = 1200000,
    parameter int CW         = $clog2(BASE_TICKS << 3)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       clr,
    input  logic [1:0] shift,
    output logic       tick
);

    logic [CW-1:0] cnt;
    logic [CW-1:0] last;

    // Largest period is BASE_TICKS<<3, so P-1 always fits in CW bits.
    always_comb begin
        last = CW'(BASE_TICKS - 1);
        case (shift)
            2'd0: last = CW'(BASE_TICKS - 1);
            2'd1: last = CW'((BASE_TICKS << 1) - 1);
            2'd2: last = CW'((BASE_TICKS << 2) - 1);
            2'd3: last = CW'((BASE_TICKS << 3) - 1);
            default: last = CW'(BASE_TICKS - 1);
        endcase
    end

    assign tick = en && (cnt == last);

    always_ff @(posedge clk) begin
        if (reset || clr || !en || tick)
            cnt <= '0;
        else
            cnt <= cnt + CW'(1);
    end

endmodule

// File: rtl/indicator_sequencer.sv
// Arbitrates the LED indicator's byte/strobe input between UART digit
// passthrough and a rotating "1".."5" chase driven by step_timer.
module indicator_sequencer
    import indicator_pkg::*;
#(
    parameter int         BASE_TICKS  = 1200000,
    parameter logic [1:0] SPEED_RESET = 2'd2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_ready,
    output logic [7:0] out_data,
    output logic       out_ready,
    output logic       running,
    output logic [1:0] speed_sel
);

    cmd_t       cmd;
    state_t     state, state_nxt;
    logic       tick;
    logic       pend;
    logic [2:0] pos;

    always_comb begin
        cmd = '0;
        if (rx_ready) begin
            cmd.pass   = (rx_data >= DIGIT_FIRST) && (rx_data <= DIGIT_LAST);
            cmd.run    = (rx_data == CMD_RUN);
            cmd.stop   = (rx_data == CMD_STOP);
            cmd.faster = (rx_data == CMD_FASTER);
            cmd.slower = (rx_data == CMD_SLOWER);
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (cmd.stop)
            state_nxt = IDLE;
        else if (cmd.run)
            state_nxt = RUN;
    end

    assign running = (state == RUN);

    always_ff @(posedge clk) begin
        if (reset)
            speed_sel <= SPEED_RESET;
        else if (cmd.faster && speed_sel != 2'd0)
            speed_sel <= speed_sel - 2'd1;
        else if (cmd.slower && speed_sel != 2'd3)
            speed_sel <= speed_sel + 2'd1;
    end

    // Any run/stop/speed command restarts the step period from zero.
    step_timer #(.BASE_TICKS(BASE_TICKS)) u_timer (
        .clk   (clk),
        .reset (reset),
        .en    (running),
        .clr   (cmd.run | cmd.stop | cmd.faster | cmd.slower),
        .shift (speed_sel),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            out_data  <= 8'h00;
            out_ready <= 1'b0;
            pos       <= '0;
            pend      <= 1'b0;
        end else begin
            out_ready <= 1'b0;
            if (cmd.pass) begin
                out_data  <= rx_data;
                out_ready <= 1'b1;
                if (tick)
                    pend <= 1'b1;
            end else if (cmd.stop) begin
                pend <= 1'b0;
            end else if (tick || pend) begin
                out_data  <= DIGIT_FIRST + {5'b0, pos};
                out_ready <= 1'b1;
                pend      <= 1'b0;
                pos       <= (pos == 3'(NUM_LEDS - 1)) ? 3'd0 : pos + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_indicator_sequencer.sv
// Directed bench for indicator_sequencer with BASE_TICKS=4, SPEED_RESET=2.
module tb_indicator_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic [7:0] out_data;
    logic       out_ready;
    logic       running;
    logic [1:0] speed_sel;

    int checks   = 0;
    int failures = 0;

    indicator_sequencer #(.BASE_TICKS(4), .SPEED_RESET(2'd2)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .out_data  (out_data),
        .out_ready (out_ready),
        .running   (running),
        .speed_sel (speed_sel)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change after a negedge; outputs are observed at the next negedge.
    task automatic idle();
        rx_ready = 1'b0;
        rx_data  = 8'h00;
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        rx_data  = 8'h00;
    endtask

    // Idle cycles until a strobe is seen; n = cycles taken, -1 on timeout.
    task automatic wait_strobe(input int maxc, output int n);
        n = 0;
        forever begin
            idle();
            n++;
            if (out_ready) break;
            if (n >= maxc) begin
                n = -1;
                break;
            end
        end
    endtask

    task automatic count_strobes(input int cycles, output int cnt);
        cnt = 0;
        repeat (cycles) begin
            idle();
            if (out_ready) cnt++;
        end
    endtask

    initial begin
        int n;
        int cnt;
        logic [7:0] exp_d;

        reset    = 1'b1;
        rx_ready = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_out_data", 32'(out_data), 32'h00);
        chk("rst_out_ready", 32'(out_ready), 32'h0);
        chk("rst_running", 32'(running), 32'h0);
        chk("rst_speed", 32'(speed_sel), 32'h2);
        reset = 1'b0;

        // Passthrough latency of one cycle, single pulse, data held after.
        send("3");
        chk("pass3_ready", 32'(out_ready), 32'h1);
        chk("pass3_data", 32'(out_data), 32'h33);
        chk("pass3_running", 32'(running), 32'h0);
        chk("pass3_speed", 32'(speed_sel), 32'h2);
        idle();
        chk("pass3_pulse_end", 32'(out_ready), 32'h0);
        chk("pass3_data_hold", 32'(out_data), 32'h33);

        // Chase: P=16, first strobe 17 cycles after "r", wrap after "5".
        send("r");
        chk("run_no_strobe", 32'(out_ready), 32'h0);
        chk("run_running", 32'(running), 32'h1);
        for (int i = 0; i < 6; i++) begin
            exp_d = 8'h31 + 8'(i % 5);
            wait_strobe(40, n);
            chk($sformatf("chase%0d_interval", i), 32'(n), 32'd16);
            chk($sformatf("chase%0d_data", i), 32'(out_data), 32'(exp_d));
        end

        // Passthrough collides with tick: digit first, deferred "2" next.
        count_strobes(15, cnt);
        chk("collide_quiet", 32'(cnt), 32'd0);
        send("5");
        chk("collide_pass_ready", 32'(out_ready), 32'h1);
        chk("collide_pass_data", 32'(out_data), 32'h35);
        idle();
        chk("collide_pend_ready", 32'(out_ready), 32'h1);
        chk("collide_pend_data", 32'(out_data), 32'h32);
        idle();
        chk("collide_pend_once", 32'(out_ready), 32'h0);
        wait_strobe(40, n);
        chk("collide_next_interval", 32'(n), 32'd14);
        chk("collide_next_data", 32'(out_data), 32'h33);

        // Faster saturates at 0 (P=4).
        send("+");
        chk("fast1_speed", 32'(speed_sel), 32'h1);
        chk("fast1_no_strobe", 32'(out_ready), 32'h0);
        send("+");
        chk("fast2_speed", 32'(speed_sel), 32'h0);
        send("+");
        chk("fast3_speed_sat", 32'(speed_sel), 32'h0);
        wait_strobe(40, n);
        chk("fast_first_data", 32'(out_data), 32'h34);
        wait_strobe(40, n);
        chk("fast_interval", 32'(n), 32'd4);
        chk("fast_data", 32'(out_data), 32'h35);

        // Slower saturates at 3 (P=32).
        for (int i = 0; i < 5; i++) begin
            send("-");
            chk($sformatf("slow%0d_speed", i), 32'(speed_sel), (i < 3) ? 32'(i + 1) : 32'd3);
            chk($sformatf("slow%0d_no_strobe", i), 32'(out_ready), 32'h0);
        end
        wait_strobe(80, n);
        chk("slow_first_data", 32'(out_data), 32'h31);
        wait_strobe(80, n);
        chk("slow_interval", 32'(n), 32'd32);
        chk("slow_data", 32'(out_data), 32'h32);

        // Stop on the tick cycle wins; junk bytes do nothing.
        count_strobes(31, cnt);
        chk("stop_pre_quiet", 32'(cnt), 32'd0);
        send("s");
        chk("stop_no_strobe", 32'(out_ready), 32'h0);
        chk("stop_running", 32'(running), 32'h0);
        send("x");
        chk("junk_x_strobe", 32'(out_ready), 32'h0);
        chk("junk_x_running", 32'(running), 32'h0);
        send("0");
        chk("junk_0_strobe", 32'(out_ready), 32'h0);
        chk("junk_0_speed", 32'(speed_sel), 32'h3);
        count_strobes(200, cnt);
        chk("stop_quiet_200", 32'(cnt), 32'd0);

        // Reset while a deferred step is pending.
        send("r");
        count_strobes(31, cnt);
        chk("rp_pre_quiet", 32'(cnt), 32'd0);
        send("5");
        chk("rp_pass_ready", 32'(out_ready), 32'h1);
        chk("rp_pass_data", 32'(out_data), 32'h35);
        reset = 1'b1;
        idle();
        chk("rp_out_data", 32'(out_data), 32'h00);
        chk("rp_out_ready", 32'(out_ready), 32'h0);
        chk("rp_running", 32'(running), 32'h0);
        chk("rp_speed", 32'(speed_sel), 32'h2);
        reset = 1'b0;
        count_strobes(40, cnt);
        chk("rp_no_stale", 32'(cnt), 32'd0);
        send("r");
        wait_strobe(40, n);
        chk("rp_restart_interval", 32'(n), 32'd16);
        chk("rp_restart_data", 32'(out_data), 32'h31);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/indicator_sequencer.md
Name: indicator_sequencer

Overview:
- Controller that sits between the UART receiver (byte plus one-cycle `ready` strobe) and the LED indicator block, which toggles LED n on receipt of ASCII digit "1".."5".
- Arbitrates the indicator's single byte/strobe input between two sources: UART passthrough of digits, and an internal "chase" sequencer that emits "1".."5" in rotation at a programmable rate.
- UART command bytes start/stop the chase and change its speed.

Parameters:
- BASE_TICKS, 1200000, clk cycles per chase step at speed_sel=0. Must be ≥2.
- SPEED_RESET, 2, speed_sel value after reset, in the range 0..3.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- rx_data  in  8  byte from UART receiver
- rx_ready  in  1  one-cycle strobe; rx_data is valid while it is high
- out_data  out  8  byte to the indicator
- out_ready  out  1  one-cycle strobe to the indicator
- running  out  1  1 while in RUN state
- speed_sel  out  2  current speed index

Behaviour:
- Reset: already decided — reset, synchronous, active-high; clock clk.
  - Reset values: out_data=8'h00, out_ready=0, state=IDLE (running=0), speed_sel=SPEED_RESET, pos=0, tick counter=0, pend=0.
  - Reset mid-operation aborts any pending emission.
- States:
  - IDLE: chase counter held at 0.
  - RUN: counter increments each cycle.
- Step period: P = BASE_TICKS << speed_sel.
  - Counter width is $clog2(BASE_TICKS<<3).
  - tick = RUN && counter==P-1; the counter wraps to 0 on tick.
- Decode of rx_ready bytes (a byte is acted on only when rx_ready=1):
  - "1".."5": passthrough request.
  - "r": IDLE->RUN. Counter cleared; pos unchanged. In RUN, "r" restarts the counter only.
  - "s": ->IDLE. Counter and pend cleared.
  - "+": speed_sel-1, saturating at 0 (faster).
  - "-": speed_sel+1, saturating at 3 (slower).
  - A speed change clears the counter.
  - All other bytes are ignored. Command bytes never produce out_ready.
- Output arbitration, evaluated every cycle. out_ready defaults to 0 (single-cycle pulses only).
  1. Passthrough request: out_data<=rx_data, out_ready<=1 on the next edge, so latency is 1 cycle.
  2. Otherwise, if (tick || pend): out_data<="1"+pos, out_ready<=1, pend<=0, pos<=(pos==4)?0:pos+1.
  3. If tick coincides with a passthrough, pend<=1 and the chase step is deferred. Ticks never queue more than one step (pend is a flag).
- Back-to-back passthrough bytes on consecutive cycles each produce a strobe; pend waits until the first free cycle.
- "s" in the same cycle as tick: stop wins, no emission.
- The out_data register holds its last value when out_ready=0.

Decomposition:
- Package indicator_pkg:
  - Command byte constants: CMD_RUN="r", CMD_STOP="s", CMD_FASTER="+", CMD_SLOWER="-", DIGIT_FIRST="1", DIGIT_LAST="5".
  - State enum {IDLE, RUN}.
  - NUM_LEDS=5.
- Sub-module step_timer: a prescaler with enable, clear, and 2-bit shift select, producing the tick pulse. Command decode, arbitration and pos tracking stay in the top module.

Test Plan (BASE_TICKS=4, SPEED_RESET=2 → P=16):
- Reset, then rx "3" at cycle 0 → out_ready=1 with out_data=8'h33 at cycle 1 only; running=0, speed_sel=2.
- rx "r" at cycle 0 → no strobe for the command; chase strobes "1","2","3","4","5","1" at cycles 17,33,49,65,81,97 (wrap verified).
- In RUN, inject rx "5" on the exact cycle tick fires → out "5" on the next cycle, and the deferred chase digit on the following cycle. Exactly one chase strobe, pos advanced once.
- Send "+" x3 → speed_sel saturates at 0, period 4. Send "-" x5 → speed_sel saturates at 3, period 32. The counter restarts on each change.
- "s" on the same cycle as tick → no chase strobe, running=0, no further strobes for 200 cycles. "x" and "0" bytes → no strobe, no state change.
- Assert reset while pend=1 and running → all outputs at reset values the next cycle; no stale strobe after reset deasserts.
